// File: rtl/aes_encrypt_sequencer_if.sv
// rtl/aes_encrypt_sequencer_if.sv - plaintext/key input, core-side and ciphertext output bundle
interface aes_encrypt_sequencer_if;
    logic         in_valid;
    logic         in_ready;
    logic [0:127] in_plaintext;
    logic [0:127] in_key;
    logic         core_enable;
    logic [0:127] core_plaintext;
    logic [0:127] core_key;
    logic [0:127] core_ciphertext;
    logic         out_valid;
    logic         out_ready;
    logic [0:127] out_ciphertext;

    modport slave (
        input  in_valid,
        input  in_plaintext,
        input  in_key,
        input  core_ciphertext,
        input  out_ready,
        output in_ready,
        output core_enable,
        output core_plaintext,
        output core_key,
        output out_valid,
        output out_ciphertext
    );

    modport master (
        output in_valid,
        output in_plaintext,
        output in_key,
        output core_ciphertext,
        output out_ready,
        input  in_ready,
        input  core_enable,
        input  core_plaintext,
        input  core_key,
        input  out_valid,
        input  out_ciphertext
    );
endinterface

// File: rtl/aes_encrypt_sequencer.sv
// rtl/aes_encrypt_sequencer.sv - load/run/capture sequencer in front of an iterative AES-128 core
module aes_encrypt_sequencer #(
    parameter int LOAD_CYCLES  = 2,
    parameter int CORE_LATENCY = 12,
    parameter int CNT_W        = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    aes_encrypt_sequencer_if.slave  bus,
    output logic                    busy,
    output logic [CNT_W-1:0]        blocks_done
);
    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        LOAD = 4'b0010,
        RUN  = 4'b0100,
        DONE = 4'b1000
    } state_t;

    localparam logic [7:0] LOAD_LAST = 8'(LOAD_CYCLES - 1);
    localparam logic [7:0] RUN_LAST  = 8'(CORE_LATENCY - 1);

    state_t       state;
    state_t       state_next;
    logic [7:0]   ctr;
    logic [7:0]   ctr_next;
    logic         capture_in;
    logic         capture_ct;
    logic         count_block;

    // One-hot state keeps every status output a single flop bit.
    assign bus.in_ready    = state[0];
    assign busy            = ~state[0];
    assign bus.core_enable = ~state[2];
    assign bus.out_valid   = state[3];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            ctr                <= 8'd0;
            bus.core_plaintext <= '0;
            bus.core_key       <= '0;
            bus.out_ciphertext <= '0;
            blocks_done        <= '0;
        end else begin
            state <= state_next;
            ctr   <= ctr_next;
            if (capture_in) begin
                bus.core_plaintext <= bus.in_plaintext;
                bus.core_key       <= bus.in_key;
            end
            if (capture_ct) begin
                bus.out_ciphertext <= bus.core_ciphertext;
            end
            if (count_block) begin
                blocks_done <= blocks_done + 1'b1;
            end
        end
    end

    always_comb begin
        state_next  = state;
        ctr_next    = ctr;
        capture_in  = 1'b0;
        capture_ct  = 1'b0;
        count_block = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    capture_in = 1'b1;
                    ctr_next   = 8'd0;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (ctr == LOAD_LAST) begin
                    ctr_next   = 8'd0;
                    state_next = RUN;
                end else begin
                    ctr_next = ctr + 8'd1;
                end
            end
            RUN: begin
                if (ctr == RUN_LAST) begin
                    ctr_next   = 8'd0;
                    capture_ct = 1'b1;
                    state_next = DONE;
                end else begin
                    ctr_next = ctr + 8'd1;
                end
            end
            DONE: begin
                // Core stays parked with enable high until the consumer takes the result.
                if (bus.out_ready) begin
                    count_block = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: begin
                ctr_next   = 8'd0;
                state_next = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_aes_encrypt_sequencer.sv
// tb/tb_aes_encrypt_sequencer.sv - randomized self-checking bench with AES core and sequencer models
module tb_aes_encrypt_sequencer;
    localparam int LC    = 2;
    localparam int CL    = 12;
    localparam int CNT_W = 2;
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic             clk;
    logic             reset;
    logic             busy;
    logic [CNT_W-1:0] blocks_done;
    int               n_checks = 0;
    int               n_fail   = 0;
    bit               cmp_en   = 0;

    aes_encrypt_sequencer_if bus();

    aes_encrypt_sequencer #(.LOAD_CYCLES(LC), .CORE_LATENCY(CL), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .busy(busy),
        .blocks_done(blocks_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] base;
        logic [7:0] r;
        logic [7:0] s;
        inv  = 8'h01;
        base = x;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) inv = gmul(inv, base);
            base = gmul(base, base);
        end
        r = inv;
        s = inv;
        for (int i = 0; i < 4; i++) begin
            r = {r[6:0], r[7]};
            s ^= r;
        end
        return s ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0]), sbox(tmp[31:24])} ^ {rc, 24'h0};
                rc  = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[r+4*c] = sbox(s[r+4*((c+r)%4)]);
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (rnd != 10) begin
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) s[i] ^= w[4*rnd + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timeout waiting for DUT", name);
    endtask

    // Core stand-in: ciphertext is correct only on the last cycle of the enable-low window.
    int           run_cnt;
    logic [127:0] core_ref;
    always @(posedge clk or posedge reset) begin
        if (reset)                 run_cnt <= 0;
        else if (bus.core_enable)  run_cnt <= 0;
        else                       run_cnt <= run_cnt + 1;
    end
    always @(bus.core_plaintext or bus.core_key) core_ref = aes_enc(bus.core_plaintext, bus.core_key);
    always_comb bus.core_ciphertext = (!bus.core_enable && run_cnt == CL - 1) ? core_ref : ~core_ref;

    // Reference: a block is busy from its handshake; result appears LC+CL edges later.
    bit           m_busy, m_ov;
    int           m_age, m_blocks;
    logic [127:0] m_pt, m_key, m_ct;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy <= 0; m_ov <= 0; m_age <= 0; m_blocks <= 0;
            m_pt <= '0; m_key <= '0; m_ct <= '0;
        end else if (!m_busy) begin
            if (bus.in_valid) begin
                m_busy <= 1; m_age <= 0;
                m_pt <= bus.in_plaintext; m_key <= bus.in_key;
            end
        end else if (m_ov) begin
            if (bus.out_ready) begin
                m_ov <= 0; m_busy <= 0;
                m_blocks <= (m_blocks + 1) % (1 << CNT_W);
            end
        end else begin
            m_age <= m_age + 1;
            if (m_age + 1 == LC + CL) begin
                m_ov <= 1;
                m_ct <= aes_enc(m_pt, m_key);
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("in_ready", bus.in_ready, !m_busy);
            check("busy", busy, m_busy);
            check("core_enable", bus.core_enable, !(m_busy && !m_ov && m_age >= LC));
            check("out_valid", bus.out_valid, m_ov);
            check("out_ciphertext", bus.out_ciphertext, m_ct);
            check("core_plaintext", bus.core_plaintext, m_pt);
            check("core_key", bus.core_key, m_key);
            check("blocks_done", blocks_done, m_blocks);
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic send(input logic [127:0] pt, input logic [127:0] key);
        int k;
        k = 0;
        while (!bus.in_ready && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        if (!bus.in_ready) timeout("send");
        bus.in_plaintext = pt;
        bus.in_key       = key;
        bus.in_valid     = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_ov(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.out_valid) timeout("wait_out_valid");
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (!bus.in_ready && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        if (!bus.in_ready) timeout("wait_idle");
    endtask

    initial begin
        int           lat, rdy_low, k, idx, got;
        bit           prev_rdy;
        logic [127:0] pt3 [3];
        logic [127:0] key3 [3];
        logic [127:0] gpt, gkey;
        int           exp_bd [5];

        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_plaintext = '0;
        bus.in_key = '0;
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        check("reset_in_ready", bus.in_ready, 1);
        check("reset_core_enable", bus.core_enable, 1);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_blocks_done", blocks_done, 0);
        check("model_fips_c1", aes_enc(C1_PT, C1_KEY), C1_CT);
        reset = 1'b0;
        cmp_en = 1;

        // FIPS-197 C.1 with the consumer always ready
        bus.out_ready = 1'b1;
        send(C1_PT, C1_KEY);
        lat = -1; rdy_low = 0; k = 0;
        while (k < 100) begin
            if (bus.in_ready) break;
            rdy_low++;
            if (bus.out_valid && lat < 0) lat = k;
            @(posedge clk); #1;
            k++;
        end
        check("c1_latency", lat, 14);
        check("c1_in_ready_low", rdy_low, 15);
        check("c1_ciphertext", bus.out_ciphertext, C1_CT);
        check("c1_blocks_done", blocks_done, 1);

        // backpressure
        bus.out_ready = 1'b0;
        send(C1_PT, C1_KEY);
        wait_ov(lat);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("bp_out_valid", bus.out_valid, 1);
            check("bp_ciphertext", bus.out_ciphertext, C1_CT);
            check("bp_in_ready", bus.in_ready, 0);
            check("bp_core_enable", bus.core_enable, 1);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_in_ready", bus.in_ready, 1);
        check("bp_release_out_valid", bus.out_valid, 0);

        // back-to-back with in_valid held high
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pt3[i] = rand128();
            key3[i] = rand128();
        end
        idx = 0; got = 0;
        prev_rdy = bus.in_ready;
        bus.in_plaintext = pt3[0];
        bus.in_key = key3[0];
        bus.in_valid = 1'b1;
        for (int c = 0; c < 300 && got < 3; c++) begin
            @(posedge clk); #1;
            if (prev_rdy && bus.in_valid) begin
                idx++;
                if (idx < 3) begin
                    bus.in_plaintext = pt3[idx];
                    bus.in_key = key3[idx];
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            if (bus.out_valid) begin
                check($sformatf("b2b_ct%0d", got), bus.out_ciphertext, aes_enc(pt3[got], key3[got]));
                got++;
            end
            prev_rdy = bus.in_ready;
        end
        if (got < 3) timeout("b2b");
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        check("b2b_blocks_done", blocks_done, 3);

        // reset five cycles into RUN
        do_reset();
        send(C1_PT, C1_KEY);
        repeat (LC + 5) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_core_enable", bus.core_enable, 1);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_core_plaintext", bus.core_plaintext, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        send(C1_PT, C1_KEY);
        wait_ov(lat);
        check("rst_after_ct", bus.out_ciphertext, C1_CT);
        wait_idle();

        // input glitching after handshake
        gpt = rand128();
        gkey = rand128();
        send(gpt, gkey);
        k = 0;
        while (!bus.out_valid && k < 100) begin
            bus.in_plaintext = rand128();
            bus.in_key = rand128();
            check("glitch_core_pt", bus.core_plaintext, gpt);
            @(posedge clk); #1;
            k++;
        end
        if (!bus.out_valid) timeout("glitch");
        check("glitch_ct", bus.out_ciphertext, aes_enc(gpt, gkey));
        wait_idle();

        // blocks_done wrap
        do_reset();
        exp_bd = '{1, 2, 3, 0, 1};
        for (int i = 0; i < 5; i++) begin
            send(C1_PT, C1_KEY);
            wait_ov(lat);
            @(posedge clk); #1;
            wait_idle();
            check($sformatf("wrap_%0d", i), blocks_done, exp_bd[i]);
        end

        // random traffic against the reference
        for (int c = 0; c < 800; c++) begin
            @(posedge clk); #1;
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_plaintext = rand128();
            bus.in_key = rand128();
            bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (40) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
